// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Constants shared by the AES cipher, key expansion and S-box:
//               the forward SubBytes table, the GF(2^8) reduction polynomial
//               and the affine constant.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // GF(2^8) reduction polynomial x^8+x^4+x^3+x+1.
  localparam logic [8:0] GF_POLY    = 9'h11B;

  // Additive constant of the SubBytes affine transform.
  localparam logic [7:0] AFFINE_C   = 8'h63;

  // Forward S-box, indexed 0xHL (row = high nibble, column = low nibble).
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Table lookup helper so every consumer resolves S(x) the same way.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return SBOX[x];
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : AES forward S-box (SubBytes) for one byte. D is a purely
//               combinational lookup usable in the same cycle B changes (key
//               expansion relies on this); D_q is a registered copy for
//               pipelined datapaths.
// Ports       : CLK   in   1  rising-edge clock
//               RST_N in   1  asynchronous active-low reset (clears D_q only)
//               B     in   8  byte to substitute
//               D     out  8  S(B), combinational, unaffected by CLK/RST_N
//               D_q   out  8  S(B) registered, 0x00 while in reset
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
  import aes_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] B,
  output logic [7:0] D,
  output logic [7:0] D_q
);

  logic [7:0] sub_d;

  // Constant ROM lookup; a full case over all 256 indices, so no latch.
  assign sub_d = sbox_fwd(B);
  assign D     = sub_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      D_q <= 8'h00;
    end else begin
      D_q <= sub_d;
    end
  end

endmodule : aes_sbox
`default_nettype wire

// File: tb/tb_aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_sbox
// Description : Self-checking bench for aes_sbox. Expected S-box values come
//               from hand-written corner vectors and from an independent
//               GF(2^8) inverse + affine model computed by the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_sbox;

  logic       clk;
  logic       rst_n;
  logic [7:0] b;
  logic [7:0] d;
  logic [7:0] d_q;

  // Key-expansion style: four parallel instances for SubWord.
  logic [7:0] kb [4];
  logic [7:0] kd [4];
  logic [7:0] kdq [4];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_s [256];

  aes_sbox u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .B     (b),
    .D     (d),
    .D_q   (d_q)
  );

  aes_sbox u_ke0 (.CLK(clk), .RST_N(rst_n), .B(kb[0]), .D(kd[0]), .D_q(kdq[0]));
  aes_sbox u_ke1 (.CLK(clk), .RST_N(rst_n), .B(kb[1]), .D(kd[1]), .D_q(kdq[1]));
  aes_sbox u_ke2 (.CLK(clk), .RST_N(rst_n), .B(kb[2]), .D(kd[2]), .D_q(kdq[2]));
  aes_sbox u_ke3 (.CLK(clk), .RST_N(rst_n), .B(kb[3]), .D(kd[3]), .D_q(kdq[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // GF(2^8) multiply modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] bb;
    logic [7:0] p;
    a  = a_in;
    bb = b_in;
    p  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ a;
      if (a[7]) a = (a << 1) ^ 8'h1B;
      else      a = a << 1;
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) r = 8'(y);
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] v);
    logic [7:0] c;
    logic [7:0] r;
    c = 8'h63;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8]
           ^ v[(i + 7) % 8] ^ c[i];
    end
    return r;
  endfunction

  initial begin
    logic [7:0] corner_in  [5];
    logic [7:0] corner_out [5];
    logic [255:0] seen;
    int n_seen;
    int n_fixed;
    int n_compl;

    corner_in  = '{8'h00, 8'h01, 8'hFF, 8'h53, 8'h10};
    corner_out = '{8'h63, 8'h7C, 8'h16, 8'hED, 8'hCA};

    for (int x = 0; x < 256; x++) exp_s[x] = affine(ginv(8'(x)));

    // Reset state, with the combinational path live during reset.
    rst_n = 1'b0;
    b     = 8'h00;
    for (int k = 0; k < 4; k++) kb[k] = 8'h00;
    #2;
    chk("reset_dq", 32'(d_q), 32'h00);
    chk("reset_d_live", 32'(d), 32'h63);

    @(negedge clk);
    rst_n = 1'b1;

    // Combinational corners.
    for (int i = 0; i < 5; i++) begin
      b = corner_in[i];
      #1;
      chk("corner", 32'(d), 32'(corner_out[i]));
    end

    // SubWord(RotWord(0x09CF4F3C)).
    kb[0] = 8'hCF; kb[1] = 8'h4F; kb[2] = 8'h3C; kb[3] = 8'h09;
    #1;
    chk("ke0", 32'(kd[0]), 32'h8A);
    chk("ke1", 32'(kd[1]), 32'h84);
    chk("ke2", 32'(kd[2]), 32'hEB);
    chk("ke3", 32'(kd[3]), 32'h01);

    // Exhaustive sweep against the arithmetic model.
    seen    = '0;
    n_fixed = 0;
    n_compl = 0;
    for (int x = 0; x < 256; x++) begin
      b = 8'(x);
      #1;
      chk("sweep", 32'(d), 32'(exp_s[x]));
      seen[d] = 1'b1;
      if (d == 8'(x))    n_fixed++;
      if (d == ~(8'(x))) n_compl++;
    end
    n_seen = 0;
    for (int x = 0; x < 256; x++) if (seen[x]) n_seen++;
    chk("distinct", 32'(n_seen), 32'd256);
    chk("fixed_pts", 32'(n_fixed), 32'd0);
    chk("compl_pts", 32'(n_compl), 32'd0);

    // Registered path: 1-cycle latency.
    @(negedge clk);
    b = 8'h00;
    @(posedge clk);
    #1;
    chk("dq_first", 32'(d_q), 32'h63);
    b = 8'h53;
    @(posedge clk);
    #1;
    chk("dq_second", 32'(d_q), 32'hED);

    // Asynchronous reset mid-cycle, no clock edge needed.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clr", 32'(d_q), 32'h00);
    b = 8'h01;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", 32'(d_q), 32'h00);
    end

    // D stays transparent while reset is asserted.
    b = 8'hCF;
    #1;
    chk("rst_d_live", 32'(d), 32'h8A);
    chk("rst_dq_hold", 32'(d_q), 32'h00);

    // Release: first edge loads S(B).
    b = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_pre_edge", 32'(d_q), 32'h00);
    @(posedge clk);
    #1;
    chk("rel_load", 32'(d_q), 32'h7C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_aes_sbox
`default_nettype wire
